// File: rtl/rei_pkg.sv
// Shared definitions for the core-local interruptor: register offsets and address decode.
package rei_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic [2:0] {
    REG_MSIP,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_NONE
  } clint_reg_e;

  // Map an in-window byte offset to a register; the low two address bits are ignored.
  function automatic clint_reg_e clint_decode(input logic [15:0] off);
    logic [15:0] word_off;
    clint_reg_e  sel;
    word_off = {off[15:2], 2'b00};
    sel      = REG_NONE;
    if (word_off == CLINT_MSIP_OFF) begin
      sel = REG_MSIP;
    end else if (word_off == CLINT_MTIMECMP_OFF) begin
      sel = REG_MTIMECMP_LO;
    end else if (word_off == (CLINT_MTIMECMP_OFF + 16'd4)) begin
      sel = REG_MTIMECMP_HI;
    end else if (word_off == CLINT_MTIME_OFF) begin
      sel = REG_MTIME_LO;
    end else if (word_off == (CLINT_MTIME_OFF + 16'd4)) begin
      sel = REG_MTIME_HI;
    end
    return sel;
  endfunction

endpackage

// File: rtl/clint_bytewrite.sv
// Masked 32-bit byte-lane merge: lanes with a set strobe take wdata, others keep old.
module clint_bytewrite (
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] new_o
);

  // Per-lane select between the stored and the written byte.
  always_comb begin
    new_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_i[i]) begin
        new_o[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp machine timer and msip, on the data bus.
// Optional build macro CLINT_TIMER_PRESCALER_EN: mtime advances once every PRESCALE
// cycles instead of every cycle.
module clint_timer
  import rei_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  BASE_ADDR = 32'h0200_0000,
  parameter int unsigned      PRESCALE  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN-1:0]   addr_i,
  input  logic              arvalid_i,
  input  logic              wvalid_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN/8-1:0] wstrb_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              mtip_o,
  output logic              msip_o
);

  logic        hit;
  logic        we;
  clint_reg_e  sel;
  logic        tick;

  logic        msip_q, msip_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_inc;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_mux;
  logic        mtip_q, mtip_d;

  logic [31:0] msip_new;
  logic [31:0] cmp_lo_new, cmp_hi_new;
  logic [31:0] mt_lo_new, mt_hi_new;

  assign hit = (addr_i[XLEN-1:16] == BASE_ADDR[XLEN-1:16]);
  assign sel = hit ? clint_decode(addr_i[15:0]) : REG_NONE;
  assign we  = wvalid_i && hit;

`ifdef CLINT_TIMER_PRESCALER_EN
  localparam int unsigned    PsW    = $clog2(PRESCALE + 1);
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_q, ps_d;

  assign tick = (ps_q == PsLast);
  assign ps_d = tick ? '0 : ps_q + PsW'(1);

  // Prescale counter; free-running, untouched by mtime writes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], msip_new[31:1]};
`else
  assign tick = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], msip_new[31:1], (PRESCALE == 0)};
`endif

  // Byte-lane merges for each writable word, always against the pre-edge value.
  clint_bytewrite u_bw_msip (
    .old_i   ({31'b0, msip_q}),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .new_o   (msip_new)
  );

  clint_bytewrite u_bw_cmp_lo (
    .old_i   (mtimecmp_q[31:0]),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .new_o   (cmp_lo_new)
  );

  clint_bytewrite u_bw_cmp_hi (
    .old_i   (mtimecmp_q[63:32]),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .new_o   (cmp_hi_new)
  );

  clint_bytewrite u_bw_mt_lo (
    .old_i   (mtime_q[31:0]),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .new_o   (mt_lo_new)
  );

  clint_bytewrite u_bw_mt_hi (
    .old_i   (mtime_q[63:32]),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .new_o   (mt_hi_new)
  );

  // Next-state: increment on tick, then a written mtime half overrides the increment.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_inc  = tick ? mtime_q + 64'd1 : mtime_q;
    mtime_d    = mtime_inc;
    if (we) begin
      case (sel)
        REG_MSIP:        msip_d            = msip_new[0];
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = cmp_lo_new;
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = cmp_hi_new;
        REG_MTIME_LO:    mtime_d[31:0]     = mt_lo_new;
        REG_MTIME_HI:    mtime_d[63:32]    = mt_hi_new;
        default:         ;
      endcase
    end
    mtip_d = (mtime_d >= mtimecmp_d);
  end

  // Read mux on pre-edge state; a miss or non-read yields zero for OR-merging.
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_MSIP:        rd_mux = {31'b0, msip_q};
      REG_MTIMECMP_LO: rd_mux = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: rd_mux = mtimecmp_q[63:32];
      REG_MTIME_LO:    rd_mux = mtime_q[31:0];
      REG_MTIME_HI:    rd_mux = mtime_q[63:32];
      default:         rd_mux = '0;
    endcase
    rdata_d = arvalid_i ? rd_mux : '0;
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      msip_q     <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      rdata_q    <= '0;
      mtip_q     <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      mtip_q     <= mtip_d;
    end
  end

  assign rdata_o = rdata_q;
  assign mtip_o  = mtip_q;
  assign msip_o  = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: table of bus vectors plus hand sequences,
// a behavioural timer model and a read-data scoreboard.
module tb_clint_timer;

`ifdef CLINT_TIMER_PRESCALER_EN
  localparam int unsigned Ps = 4;
`else
  localparam int unsigned Ps = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        arv = 1'b0;
  logic        wv = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        mtip;
  logic        msip;

  always #5 clk = ~clk;

  clint_timer #(
    .XLEN      (32),
    .BASE_ADDR (32'h0200_0000),
    .PRESCALE  (Ps)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .addr_i    (addr),
    .arvalid_i (arv),
    .wvalid_i  (wv),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .rdata_o   (rdata),
    .mtip_o    (mtip),
    .msip_o    (msip)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  // Behavioural model of the architectural state
  logic [63:0] m_mt;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic        m_mtip;
  int          m_ps;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        ue;
    logic [31:0] e;
    string       n;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s, input logic ue,
                             input logic [31:0] e, input string n);
    vec_t x;
    x.r = r; x.w = w; x.a = a; x.d = d; x.s = s; x.ue = ue; x.e = e; x.n = n;
    return x;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:16] == 16'h0200) begin
      case ({a[15:2], 2'b00})
        16'h0000: r = {31'b0, m_msip};
        16'h4000: r = m_cmp[31:0];
        16'h4004: r = m_cmp[63:32];
        16'hBFF8: r = m_mt[31:0];
        16'hBFFC: r = m_mt[63:32];
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic model_edge();
    logic        tk;
    logic [63:0] nm;
    if (!rst_n) begin
      m_mt = '0; m_cmp = '1; m_msip = 1'b0; m_mtip = 1'b0; m_ps = 0;
      return;
    end
    tk   = (m_ps == int'(Ps) - 1);
    m_ps = tk ? 0 : m_ps + 1;
    nm   = tk ? m_mt + 64'd1 : m_mt;
    if (wv && addr[31:16] == 16'h0200) begin
      case ({addr[15:2], 2'b00})
        16'h0000: if (wstrb[0]) m_msip = wdata[0];
        16'h4000: m_cmp[31:0]  = merge(m_cmp[31:0], wdata, wstrb);
        16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], wdata, wstrb);
        16'hBFF8: nm[31:0]     = merge(m_mt[31:0], wdata, wstrb);
        16'hBFFC: nm[63:32]    = merge(m_mt[63:32], wdata, wstrb);
        default:  ;
      endcase
    end
    m_mt   = nm;
    m_mtip = (m_mt >= m_cmp);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One bus cycle: drive, predict, clock, then compare outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string name, input logic ue = 1'b0,
                      input logic [31:0] e = '0);
    arv = r; wv = w; addr = a; wdata = d; wstrb = s;
    exp_q.push_back(ue ? e : (r ? model_read(a) : 32'h0));
    @(posedge clk);
    model_edge();
    #1;
    last_rd = rdata;
    chk({name, " rdata"}, rdata, exp_q.pop_front());
    chk({name, " mtip"}, {31'b0, mtip}, {31'b0, m_mtip});
    chk({name, " msip"}, {31'b0, msip}, {31'b0, m_msip});
    arv = 1'b0; wv = 1'b0;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0;
    logic        seen;
    logic        prev_mtip;

    // Reset held for two cycles
    rst_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, "reset", 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, "reset", 1'b1, 32'h0);
    chk("reset mtip", {31'b0, mtip}, 32'h0);
    chk("reset msip", {31'b0, msip}, 32'h0);
    rst_n = 1'b1;

    idle(10, "run");
    step(1'b1, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, "mtime_run");
    chk("mtime_nonzero", {31'b0, (last_rd != 32'h0)}, 32'h1);
    step(1'b1, 1'b0, 32'h0200_4000, 32'h0, 4'h0, "cmp_reset", 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 32'h0200_4004, 32'h0, 4'h0, "cmp_hi_reset", 1'b1, 32'hFFFF_FFFF);

    // Table of single-cycle bus vectors
    tbl.push_back(v(0, 1, 32'h0200_4000, 32'h1234_5678, 4'hF, 0, 0, "cmp_lo_wr"));
    tbl.push_back(v(0, 1, 32'h0200_4000, 32'hAA00_0000, 4'h8, 0, 0, "cmp_byte_wr"));
    tbl.push_back(v(1, 0, 32'h0200_4000, 32'h0, 4'h0, 1, 32'hAA34_5678, "cmp_byte_rd"));
    tbl.push_back(v(1, 0, 32'h0200_4002, 32'h0, 4'h0, 1, 32'hAA34_5678, "addr_lsb_ign"));
    tbl.push_back(v(0, 1, 32'h0200_4004, 32'h0000_BEEF, 4'h3, 0, 0, "cmp_hi_wr"));
    tbl.push_back(v(1, 0, 32'h0200_4004, 32'h0, 4'h0, 1, 32'hFFFF_BEEF, "cmp_hi_rd"));
    tbl.push_back(v(0, 1, 32'h0200_0000, 32'h0000_0001, 4'hF, 0, 0, "msip_set"));
    tbl.push_back(v(1, 0, 32'h0200_0000, 32'h0, 4'h0, 1, 32'h1, "msip_rd"));
    tbl.push_back(v(1, 0, 32'h0300_0000, 32'h0, 4'h0, 1, 32'h0, "miss_rd"));
    tbl.push_back(v(1, 0, 32'h0200_0100, 32'h0, 4'h0, 1, 32'h0, "hole_rd"));
    tbl.push_back(v(0, 1, 32'h0300_0000, 32'h0, 4'hF, 0, 0, "miss_wr"));
    tbl.push_back(v(0, 1, 32'h0200_0000, 32'h0, 4'h2, 0, 0, "msip_lane1"));
    tbl.push_back(v(1, 0, 32'h0200_0000, 32'h0, 4'h0, 1, 32'h1, "msip_kept"));
    tbl.push_back(v(0, 1, 32'h0200_0104, 32'hFFFF_FFFF, 4'hF, 0, 0, "hole_wr"));
    tbl.push_back(v(1, 0, 32'h0200_0104, 32'h0, 4'h0, 1, 32'h0, "hole_rd2"));
    tbl.push_back(v(1, 1, 32'h0200_0000, 32'h0, 4'hF, 1, 32'h1, "rw_same"));
    tbl.push_back(v(1, 0, 32'h0200_0000, 32'h0, 4'h0, 1, 32'h0, "msip_clr"));
    tbl.push_back(v(0, 1, 32'h0200_BFF8, 32'h0000_0100, 4'hF, 0, 0, "mt_wr"));
    tbl.push_back(v(1, 0, 32'h0200_BFF8, 32'h0, 4'h0, 1, 32'h0000_0100, "mt_wr_prio"));
    tbl.push_back(v(0, 1, 32'h0200_BFF8, 32'h0000_00AA, 4'h1, 0, 0, "mt_lane"));
    tbl.push_back(v(1, 0, 32'h0200_BFF8, 32'h0, 4'h0, 0, 0, "mt_lane_rd"));
    tbl.push_back(v(1, 0, 32'h0200_BFFC, 32'h0, 4'h0, 1, 32'h0, "mt_hi_rd"));
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].n, tbl[i].ue, tbl[i].e);
    end

    // mtip rises in the cycle mtime reaches 20, then falls after mtimecmp is raised
    step(1'b0, 1'b1, 32'h0200_BFF8, 32'h0, 4'hF, "mt_lo0");
    step(1'b0, 1'b1, 32'h0200_BFFC, 32'h0, 4'hF, "mt_hi0");
    step(1'b0, 1'b1, 32'h0200_4000, 32'd20, 4'hF, "cmp_lo20");
    step(1'b0, 1'b1, 32'h0200_4004, 32'h0, 4'hF, "cmp_hi0");
    chk("mtip_low_before", {31'b0, mtip}, 32'h0);
    seen = 1'b0;
    prev_mtip = mtip;
    for (int i = 0; i < 200 && !seen; i++) begin
      step(1'b1, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, "mtip_wait");
      if (mtip && !prev_mtip) begin
        seen = 1'b1;
        chk("mtip_rise_prev_mtime", last_rd, 32'd19);
      end
      prev_mtip = mtip;
    end
    chk("mtip_rise_seen", {31'b0, seen}, 32'h1);
    step(1'b0, 1'b1, 32'h0200_4000, 32'h0000_FFFF, 4'hF, "cmp_raise");
    chk("mtip_fall", {31'b0, mtip}, 32'h0);

    // Carry from the low to the high mtime half
    step(1'b0, 1'b1, 32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF, "carry_lo");
    step(1'b0, 1'b1, 32'h0200_BFFC, 32'h0, 4'hF, "carry_hi");
    if (Ps == 1) begin
      idle(1, "carry_idle");
      step(1'b1, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, "carry_lo_rd", 1'b1, 32'h0);
      step(1'b1, 1'b0, 32'h0200_BFFC, 32'h0, 4'h0, "carry_hi_rd", 1'b1, 32'h1);
    end else begin
      idle(2 * Ps, "carry_idle");
      step(1'b1, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, "carry_lo_rd");
      step(1'b1, 1'b0, 32'h0200_BFFC, 32'h0, 4'h0, "carry_hi_rd", 1'b1, 32'h1);
    end

    // mtime advance over 20 cycles
    step(1'b0, 1'b1, 32'h0200_BFFC, 32'h0, 4'hF, "adv_hi0");
    step(1'b1, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, "adv_rd0");
    a0 = last_rd;
    idle(19, "adv_idle");
    step(1'b1, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, "adv_rd1");
    chk("mtime_advance_20cyc", last_rd - a0, 32'd20 / Ps);

    // mtime write landing on a tick edge keeps the written value
    for (int i = 0; i < 2 * int'(Ps) && m_ps != int'(Ps) - 1; i++) idle(1, "align");
    step(1'b0, 1'b1, 32'h0200_BFF8, 32'h0000_0500, 4'hF, "tick_wr");
    step(1'b1, 1'b0, 32'h0200_BFF8, 32'h0, 4'h0, "tick_wr_rd", 1'b1, 32'h0000_0500);

    // Reset mid-run restores reset state
    rst_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, "rerst", 1'b1, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h0200_4000, 32'h0, 4'h0, "rerst_cmp", 1'b1, 32'hFFFF_FFFF);

    if (exp_q.size() != 0) chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
